riscv_shared_dsp_if: RTL and testbench

Sequential EX-stage companion to the basic ALU in shared-DSP core configurations. It captures ALU operations the basic ALU does not implement (MIN/MAX/ABS/CLIP/CLIPU, bit-count, bit-manipulation). It forwards them to the cluster-shared DSP over a req/gnt/rvalid handshake and returns the result to the EX stage with a ready_o/ex_ready_i stall handshake. The EX stage muxes result_o with the basic ALU result.

---
 rtl/riscv_shared_dsp_if.sv | 146 ++++++++++++++
 tb/tb_riscv_shared_dsp_if.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_shared_dsp_if.sv
// Sequential EX-stage bridge that forwards ALU ops missing from the basic ALU to the cluster-shared DSP.
// Optional WAIT-state timeout is enabled by defining SHARED_DSP_TIMEOUT_EN.
module riscv_shared_dsp_if #(
    parameter int ALU_OP_WIDTH   = 7,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_a_i,
    input  logic [31:0]             operand_b_i,
    input  logic [31:0]             operand_c_i,
    input  logic [2:0]              vector_mode_i,
    input  logic                    flush_i,
    input  logic                    ex_ready_i,
    output logic [31:0]             result_o,
    output logic                    ready_o,
    output logic                    err_o,
    output logic                    dsp_req_o,
    input  logic                    dsp_gnt_i,
    output logic [ALU_OP_WIDTH-1:0] dsp_op_o,
    output logic [31:0]             dsp_op_a_o,
    output logic [31:0]             dsp_op_b_o,
    output logic [31:0]             dsp_op_c_o,
    output logic [2:0]              dsp_vec_mode_o,
    input  logic                    dsp_rvalid_i,
    input  logic [31:0]             dsp_rdata_i
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t state;

`ifdef SHARED_DSP_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;
`else
    assign err_o = 1'b0;
`endif

    // IDLE only counts as ready when EX has no shared-DSP op pending this cycle.
    assign ready_o = (state == DONE) || ((state == IDLE) && !enable_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            dsp_req_o      <= 1'b0;
            dsp_op_o       <= '0;
            dsp_op_a_o     <= '0;
            dsp_op_b_o     <= '0;
            dsp_op_c_o     <= '0;
            dsp_vec_mode_o <= '0;
            result_o       <= '0;
`ifdef SHARED_DSP_TIMEOUT_EN
            err_o          <= 1'b0;
            wait_cnt       <= '0;
            timed_out      <= 1'b0;
`endif
        end else begin
`ifdef SHARED_DSP_TIMEOUT_EN
            err_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (enable_i && !flush_i) begin
                        dsp_op_o       <= operator_i;
                        dsp_op_a_o     <= operand_a_i;
                        dsp_op_b_o     <= operand_b_i;
                        dsp_op_c_o     <= operand_c_i;
                        dsp_vec_mode_o <= vector_mode_i;
                        dsp_req_o      <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    // A granted request owes us an rvalid even if EX no longer wants it.
                    if (dsp_gnt_i) begin
                        dsp_req_o <= 1'b0;
                        state     <= flush_i ? DRAIN : WAIT;
`ifdef SHARED_DSP_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else if (flush_i) begin
                        dsp_req_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WAIT: begin
                    if (dsp_rvalid_i) begin
                        if (!flush_i) begin
                            result_o <= dsp_rdata_i;
                        end
                        state <= flush_i ? IDLE : DONE;
                    end else if (flush_i) begin
                        state <= DRAIN;
`ifdef SHARED_DSP_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        result_o  <= '0;
                        err_o     <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    if (ex_ready_i || flush_i) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
`ifdef SHARED_DSP_TIMEOUT_EN
                    // A timed-out op still reports its zero result unless EX has flushed it meanwhile.
                    if (flush_i) begin
                        timed_out <= 1'b0;
                    end
                    if (dsp_rvalid_i) begin
                        timed_out <= 1'b0;
                        state     <= (timed_out && !flush_i) ? DONE : IDLE;
                    end
`else
                    if (dsp_rvalid_i) begin
                        state <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // The DSP may only answer while a granted request is outstanding.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(dsp_rvalid_i && (state == IDLE || state == REQ || state == DONE)));
            assert (TIMEOUT_CYCLES > 0);
        end
    end
`endif

endmodule

// File: tb/tb_riscv_shared_dsp_if.sv
// Self-checking bench for riscv_shared_dsp_if: the bench plays the shared DSP and predicts
// results and stall lengths from a behavioural ALU model and the handshake latency rules.
module tb_riscv_shared_dsp_if;

    localparam logic [6:0] ALU_MIN  = 7'b0010000;
    localparam logic [6:0] ALU_MINU = 7'b0010001;
    localparam logic [6:0] ALU_MAX  = 7'b0010010;
    localparam logic [6:0] ALU_MAXU = 7'b0010011;
    localparam logic [6:0] ALU_ABS  = 7'b0010100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic [6:0]  operator_i;
    logic [31:0] operand_a_i, operand_b_i, operand_c_i;
    logic [2:0]  vector_mode_i;
    logic        flush_i;
    logic        ex_ready_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        err_o;
    logic        dsp_req_o;
    logic        dsp_gnt_i;
    logic [6:0]  dsp_op_o;
    logic [31:0] dsp_op_a_o, dsp_op_b_o, dsp_op_c_o;
    logic [2:0]  dsp_vec_mode_o;
    logic        dsp_rvalid_i;
    logic [31:0] dsp_rdata_i;

    int          tests_run = 0;
    int          fail_count = 0;
    logic [31:0] last_result;
    logic [6:0]  op_table [5] = '{ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU, ALU_ABS};

    riscv_shared_dsp_if #(.ALU_OP_WIDTH(7), .TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .operator_i     (operator_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .operand_c_i    (operand_c_i),
        .vector_mode_i  (vector_mode_i),
        .flush_i        (flush_i),
        .ex_ready_i     (ex_ready_i),
        .result_o       (result_o),
        .ready_o        (ready_o),
        .err_o          (err_o),
        .dsp_req_o      (dsp_req_o),
        .dsp_gnt_i      (dsp_gnt_i),
        .dsp_op_o       (dsp_op_o),
        .dsp_op_a_o     (dsp_op_a_o),
        .dsp_op_b_o     (dsp_op_b_o),
        .dsp_op_c_o     (dsp_op_c_o),
        .dsp_vec_mode_o (dsp_vec_mode_o),
        .dsp_rvalid_i   (dsp_rvalid_i),
        .dsp_rdata_i    (dsp_rdata_i)
    );

    always #5 clk = ~clk;

    // What the shared DSP should compute for a 32-bit scalar op.
    function automatic logic [31:0] dspModel(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_MIN:  return ($signed(a) < $signed(b)) ? a : b;
            ALU_MINU: return (a < b) ? a : b;
            ALU_MAX:  return ($signed(a) > $signed(b)) ? a : b;
            ALU_MAXU: return (a > b) ? a : b;
            ALU_ABS:  return ($signed(a) < 0) ? (32'd0 - a) : a;
            default:  return a ^ b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents an op in IDLE for one cycle; returns with the DUT expected in REQ.
    task automatic startOp(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        enable_i      = 1'b1;
        operator_i    = op;
        operand_a_i   = a;
        operand_b_i   = b;
        operand_c_i   = $urandom;
        vector_mode_i = 3'b010;
        @(negedge clk);
        checkOutput("start_ready", ready_o, 0);
        nextCycle();
        enable_i = 1'b0;
    endtask

    // One complete op with gd grant-wait cycles, rd rvalid-wait cycles and hold cycles of EX stall in DONE.
    task automatic applyStimulus(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input int gd, input int rd, input int hold);
        logic [31:0] expected;
        int          stall_cycles;
        int          req_cycles;
        expected     = dspModel(op, a, b);
        stall_cycles = 0;
        req_cycles   = 0;
        enable_i      = 1'b1;
        operator_i    = op;
        operand_a_i   = a;
        operand_b_i   = b;
        operand_c_i   = c;
        vector_mode_i = 3'b000;
        ex_ready_i    = 1'b1;
        @(negedge clk);
        if (ready_o !== 1'b1) stall_cycles++;
        if (dsp_req_o === 1'b1) req_cycles++;
        nextCycle();
        enable_i      = 1'b0;
        operator_i    = 7'($urandom);
        operand_a_i   = $urandom;
        operand_b_i   = $urandom;
        operand_c_i   = $urandom;
        vector_mode_i = 3'($urandom);
        for (int i = 0; i <= gd; i++) begin
            dsp_gnt_i = (i == gd);
            @(negedge clk);
            if (ready_o !== 1'b1) stall_cycles++;
            if (dsp_req_o === 1'b1) req_cycles++;
            checkOutput("payload_op", dsp_op_o, op);
            checkOutput("payload_a", dsp_op_a_o, a);
            checkOutput("payload_b", dsp_op_b_o, b);
            checkOutput("payload_c", dsp_op_c_o, c);
            checkOutput("payload_vec", dsp_vec_mode_o, 0);
            nextCycle();
        end
        dsp_gnt_i = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            dsp_rvalid_i = (i == rd);
            dsp_rdata_i  = (i == rd) ? expected : $urandom;
            @(negedge clk);
            if (ready_o !== 1'b1) stall_cycles++;
            if (dsp_req_o === 1'b1) req_cycles++;
            checkOutput("wait_err", err_o, 0);
            nextCycle();
        end
        dsp_rvalid_i = 1'b0;
        dsp_rdata_i  = $urandom;
        for (int i = 0; i <= hold; i++) begin
            ex_ready_i = (i == hold);
            @(negedge clk);
            if (ready_o !== 1'b1) stall_cycles++;
            if (dsp_req_o === 1'b1) req_cycles++;
            checkOutput("done_ready", ready_o, 1);
            checkOutput("done_result", result_o, expected);
            nextCycle();
        end
        ex_ready_i = 1'b1;
        checkOutput("stall_cycles", stall_cycles, 3 + gd + rd);
        checkOutput("req_cycles", req_cycles, gd + 1);
        // Back in IDLE: a pending-but-flushed op must drop ready, which DONE never would.
        enable_i = 1'b1;
        flush_i  = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_done", ready_o, 0);
        checkOutput("idle_result", result_o, expected);
        nextCycle();
        enable_i = 1'b0;
        flush_i  = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", ready_o, 1);
        checkOutput("idle_req", dsp_req_o, 0);
        nextCycle();
        last_result = expected;
    endtask

    initial begin
        rst_n         = 1'b0;
        enable_i      = 1'b0;
        operator_i    = '0;
        operand_a_i   = '0;
        operand_b_i   = '0;
        operand_c_i   = '0;
        vector_mode_i = '0;
        flush_i       = 1'b0;
        ex_ready_i    = 1'b1;
        dsp_gnt_i     = 1'b0;
        dsp_rvalid_i  = 1'b0;
        dsp_rdata_i   = '0;
        last_result   = '0;

        nextCycle();
        @(negedge clk);
        checkOutput("reset_req", dsp_req_o, 0);
        checkOutput("reset_err", err_o, 0);
        checkOutput("reset_result", result_o, 0);
        checkOutput("reset_payload_a", dsp_op_a_o, 0);
        checkOutput("reset_ready", ready_o, 1);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Minimum-latency MIN, then grant withheld, then EX stalled in DONE.
        applyStimulus(ALU_MIN, 32'hFFFF_FFF0, 32'd5, 32'd0, 0, 0, 0);
        applyStimulus(ALU_MAX, $urandom, $urandom, $urandom, 4, 0, 0);
        applyStimulus(ALU_MAXU, $urandom, $urandom, $urandom, 0, 1, 3);

        // Flush in REQ before grant withdraws the request.
        startOp(ALU_MINU, $urandom, $urandom);
        flush_i = 1'b1;
        @(negedge clk);
        checkOutput("flush_req_req", dsp_req_o, 1);
        checkOutput("flush_req_vec", dsp_vec_mode_o, 3'b010);
        nextCycle();
        flush_i = 1'b0;
        @(negedge clk);
        checkOutput("flush_req_dropped", dsp_req_o, 0);
        checkOutput("flush_req_ready", ready_o, 1);
        checkOutput("flush_req_result", result_o, last_result);
        nextCycle();

        // Flush in WAIT; the orphaned DEADBEEF must be drained and discarded.
        startOp(ALU_MAX, $urandom, $urandom);
        dsp_gnt_i = 1'b1;
        nextCycle();
        dsp_gnt_i = 1'b0;
        flush_i   = 1'b1;
        @(negedge clk);
        checkOutput("flush_wait_ready", ready_o, 0);
        nextCycle();
        flush_i = 1'b0;
        @(negedge clk);
        checkOutput("drain_ready_0", ready_o, 0);
        nextCycle();
        dsp_rvalid_i = 1'b1;
        dsp_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("drain_ready_1", ready_o, 0);
        nextCycle();
        dsp_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput("drain_result_kept", result_o, last_result);
        checkOutput("drain_idle_ready", ready_o, 1);
        nextCycle();
        applyStimulus(ALU_ABS, 32'hFFFF_FFF9, $urandom, $urandom, 1, 2, 0);
        checkOutput("abs_minus7", last_result, 32'd7);

        // Flush coinciding with grant still has to swallow the response.
        startOp(ALU_MIN, $urandom, $urandom);
        dsp_gnt_i = 1'b1;
        flush_i   = 1'b1;
        nextCycle();
        dsp_gnt_i    = 1'b0;
        flush_i      = 1'b0;
        dsp_rvalid_i = 1'b1;
        dsp_rdata_i  = $urandom;
        @(negedge clk);
        checkOutput("flush_gnt_ready", ready_o, 0);
        nextCycle();
        dsp_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput("flush_gnt_result", result_o, last_result);
        checkOutput("flush_gnt_idle", ready_o, 1);
        nextCycle();

        // Flush coinciding with rvalid discards the data.
        startOp(ALU_MAXU, $urandom, $urandom);
        dsp_gnt_i = 1'b1;
        nextCycle();
        dsp_gnt_i    = 1'b0;
        dsp_rvalid_i = 1'b1;
        flush_i      = 1'b1;
        dsp_rdata_i  = ~last_result;
        nextCycle();
        dsp_rvalid_i = 1'b0;
        flush_i      = 1'b0;
        @(negedge clk);
        checkOutput("flush_rvalid_result", result_o, last_result);
        checkOutput("flush_rvalid_idle", ready_o, 1);
        nextCycle();

        for (int n = 0; n < 8; n++) begin
            applyStimulus(op_table[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef SHARED_DSP_TIMEOUT_EN
        // No rvalid: 8 WAIT cycles, one err pulse, late data drained, DONE with zero.
        startOp(ALU_MAXU, $urandom, $urandom);
        dsp_gnt_i = 1'b1;
        nextCycle();
        dsp_gnt_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("to_wait_err", err_o, 0);
            checkOutput("to_wait_ready", ready_o, 0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("to_err_pulse", err_o, 1);
        checkOutput("to_result_zero", result_o, 0);
        checkOutput("to_drain_ready", ready_o, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("to_err_single", err_o, 0);
        nextCycle();
        dsp_rvalid_i = 1'b1;
        dsp_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("to_late_ready", ready_o, 0);
        nextCycle();
        dsp_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput("to_done_ready", ready_o, 1);
        checkOutput("to_done_result", result_o, 0);
        nextCycle();
        last_result = '0;
`endif

        // Reset in the middle of WAIT abandons the op outright.
        applyStimulus(ALU_MIN, $urandom | 32'h1, $urandom | 32'h1, $urandom, 0, 0, 0);
        startOp(ALU_MAX, $urandom, $urandom);
        dsp_gnt_i = 1'b1;
        nextCycle();
        dsp_gnt_i = 1'b0;
        rst_n     = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_req", dsp_req_o, 0);
        checkOutput("midrst_err", err_o, 0);
        checkOutput("midrst_result", result_o, 0);
        checkOutput("midrst_payload_op", dsp_op_o, 0);
        checkOutput("midrst_payload_b", dsp_op_b_o, 0);
        checkOutput("midrst_ready", ready_o, 1);
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
